// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
// The optional leading-zero mask of bin2bcd_seq is enabled with BIN2BCD_LZ_EN.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // ceil(width * log10(2)) in fixed point; width*log10(2) is never an exact integer for width > 0
    function automatic int unsigned bcd_digits_needed(input int unsigned width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Single BCD nibble pre-shift correction: adds 3 when the digit is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adjusted = digit + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Define BIN2BCD_LZ_EN to add the registered leading-zero mask output o_lz_mask.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_binary,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
`ifdef BIN2BCD_LZ_EN
    ,
    output logic [DIGITS-1:0]     o_lz_mask
`endif
);

    localparam int unsigned     WORK_W   = 4 * DIGITS;
    localparam int unsigned     CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t              state;
    logic [BIN_W-1:0]    shift_reg;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_adj;
    logic [WORK_W-1:0]   work_next;
    logic                carry_out;
    logic                ovf_acc;
    logic [CNT_W-1:0]    cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (work[4*g +: 4]),
            .adjusted (work_adj[4*g +: 4])
        );
    end

    // Bit leaving the top digit is a decimal carry past the last digit, i.e. overflow.
    always_comb begin
        work_next = {work_adj[WORK_W-2:0], shift_reg[BIN_W-1]};
        carry_out = work_adj[WORK_W-1];
    end

`ifdef BIN2BCD_LZ_EN
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] lz_next;
    logic              zero_above;

    always_comb begin
        lz_next    = '0;
        zero_above = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (work_next[4*k +: 4] == 4'd0);
            lz_next[k] = zero_above;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            work      <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_bcd     <= '0;
            o_ovf     <= 1'b0;
`ifdef BIN2BCD_LZ_EN
            o_lz_mask <= LZ_RST;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        shift_reg <= i_binary;
                        work      <= '0;
                        cnt       <= '0;
                        ovf_acc   <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    work      <= work_next;
                    ovf_acc   <= ovf_acc | carry_out;
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        o_bcd  <= work_next;
                        o_ovf  <= ovf_acc | carry_out;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
`ifdef BIN2BCD_LZ_EN
                        o_lz_mask <= lz_next;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Clocked, parametrised successor to the team's combinational double-dabble converter.
- Converts a BIN_W-bit unsigned binary value to DIGITS packed BCD nibbles, one bit per clock.
- Uses a start/busy/done handshake.
- Sits between sensor-value formatting logic (e.g. lux readings) and the LCD character writer; trades latency for a small, fixed adder count.

Parameters:
- BIN_W, 16: width of binary input; legal range 4..32.
- DIGITS, 5: number of BCD output digits; legal range 1..10.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  conversion request, sampled on i_clk.
- i_binary  input  BIN_W  unsigned value, captured when a start is accepted.
- o_busy  output  1  conversion in progress.
- o_done  output  1  one-cycle pulse: o_bcd/o_ovf updated.
- o_bcd  output  4*DIGITS  result; digit k in bits [4k+3:4k]; digit 0 is the units digit.
- o_ovf  output  1  value did not fit in DIGITS digits.
- o_lz_mask  output  DIGITS  leading-zero mask; present only with BIN2BCD_LZ_EN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - o_busy=0, o_done=0, o_bcd=0, o_ovf=0, o_lz_mask=all ones except bit 0.
  - Internal shift register and counter are cleared.
- States: IDLE, SHIFT.
- IDLE:
  - i_start=1 at an edge: capture i_binary into the shift register, clear the BCD work register, clear the counter and ovf accumulator, set o_busy=1, go to SHIFT.
  - i_start=0: hold state.
- SHIFT, every edge:
  - Step 1: each work nibble >=5 gets +3 (4-bit add, no carry between nibbles).
  - Step 2: shift {work, shiftreg} left by one; the MSB of shiftreg enters work bit 0.
  - The bit shifted out of work MSB is ORed into the ovf accumulator.
  - The counter increments.
- Last SHIFT edge (counter == BIN_W-1):
  - o_bcd <= final work value; o_ovf <= accumulator (including this edge's shift-out).
  - o_done <= 1, o_busy <= 0, return to IDLE.
- Latency: start accepted at edge E0 -> o_done high for exactly one cycle after edge E0+BIN_W. o_busy is high during the same BIN_W cycles.
- o_done deasserts at the next edge unconditionally.
- o_bcd and o_ovf hold their value between completions; they never show partial results.
- Start while busy: ignored. No queueing; i_binary is not re-sampled.
- Start in the o_done cycle: accepted (state is IDLE). Back-to-back throughput is one conversion per BIN_W cycles.
- i_binary changes after acceptance: no effect.
- Overflow: when o_ovf=1, o_bcd holds the low DIGITS digits of the true decimal value (mod 10^DIGITS).
- Reset mid-conversion: abort immediately, no o_done, outputs return to reset values.
- Value 0: o_bcd=0, o_ovf=0, done after BIN_W cycles as normal.

Optional Feature:
- Macro: BIN2BCD_LZ_EN.
- Defined:
  - o_lz_mask is registered alongside o_bcd.
  - Bit k=1 when digit k and all higher digits are zero, for k>=1.
  - Bit 0 is always 0, so units are always displayed.
  - The LCD writer uses the mask to print spaces.
- Not defined: the o_lz_mask port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bin2bcd_pkg:
  - State encoding (IDLE=1'b0, SHIFT=1'b1).
  - Function bcd_digits_needed(width) = ceil(width*log10(2)), used by integrators to size DIGITS.
  - Constant BCD_ADJ_THRESH=5.
- Sub-module bcd_digit_adj: combinational 4-bit nibble, adds 3 when >=5. bin2bcd_seq instantiates it DIGITS times via generate.

Test Plan:
- Defaults, start with i_binary=0 -> o_done 16 cycles after acceptance; o_bcd=20'h00000; o_ovf=0; o_busy high exactly 16 cycles.
- i_binary=16'hFFFF -> o_bcd=20'h65535, o_ovf=0. Then i_binary=12345 started in the o_done cycle -> accepted; next o_done 16 cycles later with o_bcd=20'h12345.
- Start 9999, then pulse i_start with i_binary=1 at cycle 5 of busy -> second start ignored; single o_done with o_bcd=20'h09999.
- Start 40000, assert i_rst at cycle 8 -> o_busy=0 immediately, no o_done, o_bcd=0. After release, start 7 -> o_bcd=20'h00007.
- BIN_W=16, DIGITS=4, i_binary=10000 -> o_ovf=1, o_bcd=16'h0000. i_binary=9999 -> o_ovf=0, o_bcd=16'h9999.
- With BIN2BCD_LZ_EN, i_binary=305 -> o_bcd=20'h00305, o_lz_mask=5'b11000. i_binary=0 -> o_lz_mask=5'b11110.
